// File: rtl/imu_spi_responder_if.sv
// imu_spi_responder_if: SPI bus between the flight-controller master and the IMU responder
interface imu_spi_responder_if;
    logic ss;
    logic sck;
    logic mosi;
    logic miso;
    modport master (output ss, sck, mosi, input miso);
    modport slave (input ss, sck, mosi, output miso);
endinterface

// File: rtl/imu_spi_responder.sv
// imu_spi_responder: SPI mode-0 slave serving a coherent snapshot of the 9-word IMU register bank
module imu_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter logic [7:0] CMD_READ = 8'hA5
) (
    input  logic clock,
    input  logic reset,
    imu_spi_responder_if.slave spi,
    input  logic wr_en,
    input  logic [3:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic busy,
    output logic frame_done,
    output logic frame_err,
    output logic [4:0] byte_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
    logic ss_prev, sck_prev;
    logic ss_s, sck_s, mosi_s;
    logic ss_fall, ss_rise, sck_rise, sck_fall;
    logic [1:0] state;
    logic [15:0] bank [9];
    logic valid;
    logic [143:0] snap;
    logic [7:0] rx, tx, tx_next, cmd;
    logic [7:0] rx_new, cmd_now;
    logic [2:0] bit_cnt;
    logic [4:0] byte_cnt, byte_inc;

    assign ss_s = ss_sync[SYNC_STAGES-1];
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_fall = ss_prev & ~ss_s;
    assign ss_rise = ~ss_prev & ss_s;
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;
    assign rx_new = {rx[6:0], mosi_s};
    assign cmd_now = (state == CMD) ? rx_new : cmd;
    assign byte_inc = (byte_cnt == 5'd31) ? byte_cnt : byte_cnt + 5'd1;
    assign busy = (state != IDLE);
    assign spi.miso = busy & tx[7];

    // Synchronize SPI pins; ss resets low so a frame already in progress at reset release never shows a falling edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ss_sync <= '0;
            sck_sync <= '0;
            mosi_sync <= '0;
            ss_prev <= 1'b0;
            sck_prev <= 1'b0;
        end else begin
            ss_sync <= {ss_sync[SYNC_STAGES-2:0], spi.ss};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            ss_prev <= ss_s;
            sck_prev <= sck_s;
        end
    end

    // Register bank written by local logic; out-of-range addresses are dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) bank[i] <= '0;
            valid <= 1'b0;
        end else if (wr_en && wr_addr <= 4'd8) begin
            bank[wr_addr] <= wr_data;
            valid <= 1'b1;
        end
    end

    // Frame engine: snapshot on select, shift on synced SCK edges, report status on deselect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            snap <= '0;
            rx <= '0;
            tx <= '0;
            tx_next <= '0;
            cmd <= '0;
            bit_cnt <= '0;
            byte_cnt <= '0;
            frame_done <= 1'b0;
            frame_err <= 1'b0;
            byte_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall) begin
                    state <= CMD;
                    snap <= {bank[0], bank[1], bank[2], bank[3], bank[4],
                             bank[5], bank[6], bank[7], bank[8]};
                    tx <= {7'b0, valid};
                    bit_cnt <= '0;
                    byte_cnt <= '0;
                end
            end else if (ss_rise) begin
                state <= IDLE;
                frame_done <= 1'b1;
                frame_err <= (bit_cnt != 3'd0) || (state == DATA && cmd != CMD_READ);
                byte_count <= byte_cnt;
            end else if (sck_rise) begin
                rx <= rx_new;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_cnt <= byte_inc;
                    snap <= {snap[135:0], 8'h00};
                    tx_next <= (cmd_now == CMD_READ) ? snap[143:136] : 8'hFF;
                    if (state == CMD) begin
                        state <= DATA;
                        cmd <= rx_new;
                    end
                end
            end else if (sck_fall) begin
                tx <= (bit_cnt == 3'd0) ? tx_next : {tx[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_imu_spi_responder.sv
// tb_imu_spi_responder: directed and randomized frames checked against a byte-level model of the IMU responder
module tb_imu_spi_responder;
    logic clock;
    logic reset;
    logic wr_en;
    logic [3:0] wr_addr;
    logic [15:0] wr_data;
    logic busy, frame_done, frame_err;
    logic [4:0] byte_count;
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [15:0] mb [9];
    logic mvalid;
    logic [7:0] tx_bytes [40];
    logic [7:0] rx_bytes [40];

    imu_spi_responder_if spi();

    imu_spi_responder dut (
        .clock(clock),
        .reset(reset),
        .spi(spi),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .byte_count(byte_count)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Count every frame_done pulse, sampled away from the active edge
    always @(negedge clock) if (frame_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        #20;
        wr_en = 1'b0;
        if (a <= 4'd8) begin
            mb[a] = d;
            mvalid = 1'b1;
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 9; k++) mb[k] = '0;
        mvalid = 1'b0;
    endtask

    task automatic run_frame(input int nbits, input int wr_bit, input string tag);
        logic [7:0] snap_m [18];
        logic v, got, err_o;
        logic [4:0] bc_o;
        logic [7:0] r, exp_b;
        int nbytes;
        for (int k = 0; k < 9; k++) begin
            snap_m[2*k] = mb[k][15:8];
            snap_m[2*k+1] = mb[k][7:0];
        end
        v = mvalid;
        r = '0;
        got = 1'b0;
        err_o = 1'b0;
        bc_o = '0;
        #100;
        spi.ss = 1'b0;
        #200;
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = tx_bytes[i/8][7 - i%8];
            if (i == wr_bit) begin
                wr_en = 1'b1;
                wr_addr = 4'd0;
                wr_data = 16'hBEEF;
                #20;
                wr_en = 1'b0;
                mb[0] = 16'hBEEF;
                mvalid = 1'b1;
                #60;
            end else begin
                #80;
            end
            spi.sck = 1'b1;
            r = {r[6:0], spi.miso};
            if (i % 8 == 7) rx_bytes[i/8] = r;
            #80;
            spi.sck = 1'b0;
        end
        #200;
        spi.ss = 1'b1;
        spi.mosi = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            if (frame_done) begin
                got = 1'b1;
                err_o = frame_err;
                bc_o = byte_count;
            end
        end
        check({tag, ".done"}, 32'(got), 32'd1);
        nbytes = nbits / 8;
        for (int k = 0; k < nbytes; k++) begin
            exp_b = (k == 0) ? {7'b0, v} :
                    (tx_bytes[0] != 8'hA5) ? 8'hFF :
                    (k <= 18) ? snap_m[k-1] : 8'h00;
            check($sformatf("%s.b%0d", tag, k), 32'(rx_bytes[k]), 32'(exp_b));
        end
        check({tag, ".count"}, 32'(bc_o), (nbytes > 31) ? 32'd31 : 32'(nbytes));
        check({tag, ".err"}, 32'(err_o),
              32'((nbits % 8 != 0) || (nbits >= 8 && tx_bytes[0] != 8'hA5)));
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        reset = 1'b0;
        spi.ss = 1'b1;
        spi.sck = 1'b0;
        spi.mosi = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clear_model();
        for (int b = 0; b < 40; b++) tx_bytes[b] = 8'($urandom);
        #100;
        reset = 1'b1;
        check("rst.miso", 32'(spi.miso), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(frame_done), 32'd0);
        check("rst.err", 32'(frame_err), 32'd0);
        check("rst.count", 32'(byte_count), 32'd0);
        #20000;
        check("idle.done_cnt", 32'(done_cnt), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);
        check("idle.miso", 32'(spi.miso), 32'd0);

        for (int i = 0; i < 9; i++) write_word(4'(i), 16'(16'h0101 * (i + 1)));
        tx_bytes[0] = 8'hA5;
        run_frame(19 * 8, -1, "read19");
        run_frame(21 * 8, -1, "read21");
        run_frame(33 * 8, -1, "read33");
        tx_bytes[0] = 8'h3C;
        run_frame(4 * 8, -1, "badcmd");
        tx_bytes[0] = 8'hA5;
        run_frame(12, -1, "part12");
        run_frame(5, -1, "part5");
        run_frame(0, -1, "empty");
        run_frame(19 * 8, -1, "after_part");
        run_frame(19 * 8, 20, "midwrite");
        run_frame(19 * 8, -1, "newroll");

        spi.ss = 1'b0;
        #200;
        for (int i = 0; i < 5; i++) begin
            spi.mosi = 1'b1;
            #80;
            spi.sck = 1'b1;
            #80;
            spi.sck = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.miso", 32'(spi.miso), 32'd0);
        check("mrst.done", 32'(frame_done), 32'd0);
        #19;
        clear_model();
        d0 = done_cnt;
        #40;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #80;
            spi.sck = 1'b1;
            #80;
            spi.sck = 1'b0;
            check($sformatf("ignored.busy%0d", i), 32'(busy), 32'd0);
        end
        spi.ss = 1'b1;
        #400;
        check("ignored.no_done", 32'(done_cnt), 32'(d0));

        write_word(4'd13, 16'h1234);
        run_frame(19 * 8, -1, "nowrite");
        write_word(4'd8, 16'hCAFE);
        run_frame(20 * 8, -1, "onewrite");

        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 3; w++) write_word(4'($urandom_range(0, 15)), 16'($urandom));
            for (int b = 0; b < 40; b++) tx_bytes[b] = 8'($urandom);
            tx_bytes[0] = ($urandom_range(0, 3) != 0) ? 8'hA5 : 8'($urandom);
            run_frame(int'($urandom_range(0, 200)), -1, $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imu_spi_responder.md
# imu_spi_responder

SPI-mode-0 slave that emulates the IMU end of the flight-controller sensor link, answering the `jb_imu` master with a coherent 9-word attitude/rate/accel frame. Sensor words are written by local logic into a register bank; each SPI frame serves a snapshot taken at chip-select assertion, so a frame never mixes old and new samples. It serves as a hardware-in-the-loop stand-in for the IMU and as the reference responder in master-side benches.

## Interface
Parameters
- `SYNC_STAGES`, 2: synchronizer depth on `ss`, `sck`, `mosi` (≥2).
- `CMD_READ`, 8'hA5: command byte selecting the read-all frame.

Ports
- `clock` in 1: system clock, 50 MHz; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `ss` in 1: SPI chip select, active low, asynchronous to `clock`.
- `sck` in 1: SPI clock, CPOL=0, asynchronous; f_sck ≤ f_clock/8.
- `mosi` in 1: SPI data from master, MSB first.
- `miso` out 1: SPI data to master, MSB first; driven 0 while `ss` high.
- `wr_en` in 1: register-bank write strobe.
- `wr_addr` in 4: word index 0..8 = roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate, accel_x, accel_y, accel_z.
- `wr_data` in 16: word to write.
- `busy` out 1: high while a frame is in progress.
- `frame_done` out 1: one-cycle pulse at frame end.
- `frame_err` out 1: qualified by `frame_done`; 1 if the frame ended mid-byte or the command was unknown.
- `byte_count` out 5: complete bytes exchanged in the last frame, saturating at 31; valid on `frame_done`.

## Operation
- Register bank: 9 × 16 bits, reset to 0. `wr_en` with `wr_addr` ≤ 8 writes on that edge; `wr_addr` 9..15 ignored. A valid flag sets on the first accepted write, clears only on reset.
- Inputs pass through `SYNC_STAGES` flops; edges detected on the synchronized copies only.
- State machine:
  - IDLE: `miso`=0, `busy`=0. On synced `ss` falling: copy bank to 144-bit snapshot (a same-cycle write is not included), load TX byte = {7'b0, valid}, present its MSB on `miso`, clear bit/byte counters → CMD.
  - CMD: on synced `sck` rising, shift `mosi` into RX; on falling, shift next TX bit out. After 8th rising edge, latch command; load next TX byte: snapshot byte 0 (roll[15:8]) if command == `CMD_READ`, else 8'hFF → DATA.
  - DATA: same shifting. After each byte, next TX byte = snapshot bytes 1..17 in order (big-endian per word, word order as `wr_addr`), 8'h00 after byte 17 for `CMD_READ`; always 8'hFF for unknown command. Received MOSI bytes in DATA are ignored.
  - Any state except IDLE: synced `ss` rising → IDLE; pulse `frame_done`; `frame_err` = (bit counter ≠ 0) OR (command latched and ≠ `CMD_READ`); `byte_count` = completed bytes including the command byte.
- `ss` rising before any full byte: `frame_done` with `byte_count`=0, `frame_err`=1 if any bits were clocked, else 0.
- `reset` asserted mid-frame: immediate return to IDLE, all outputs to reset values, no `frame_done`; after release, a frame already in progress (ss low) is ignored until `ss` goes high and falls again.

## Timing
- Reset values: `miso`=0, `busy`=0, `frame_done`=0, `frame_err`=0, `byte_count`=0.
- `ss` fall → `miso` valid MSB and `busy`=1: SYNC_STAGES+1 clocks (3 at default); master must delay first `sck` rise ≥4 clocks after `ss` fall.
- `sck` fall → next `miso` bit: SYNC_STAGES+1 clocks; meets mode-0 setup for f_sck ≤ f_clock/8.
- `ss` rise → `frame_done` pulse and `busy`=0: SYNC_STAGES+1 clocks.
- Register write to snapshot-visible: next frame whose synced `ss` fall occurs ≥1 clock after the write edge.

## Test plan
- Reset release, no frame: `miso`=0, `busy`=0, `frame_done` never pulses over 1000 clocks.
- Write words 0..8 = 16'h0101·(i+1); master sends 8'hA5 then 18 dummy bytes at 6.25 MHz -> MISO bytes 8'h01, then 01,01,02,02,…,09,09; `frame_done` with `byte_count`=19, `frame_err`=0.
- Same, 21 bytes total -> bytes 20–21 are 8'h00; `byte_count`=21.
- Command 8'h3C, 3 further bytes -> MISO 8'h01, FF, FF, FF; `frame_err`=1, `byte_count`=4.
- Raise `ss` after 12 bits -> `frame_done`, `frame_err`=1, `byte_count`=1; next full frame correct.
- Write roll=16'hBEEF mid-frame -> current frame returns old roll; next frame returns BE, EF; `reset` low mid-frame -> `busy`=0 immediately, no `frame_done`.
